// File: rtl/ram_2r1w_access_ctrl.sv
// Request-side controller in front of a 2R1W RAM macro (shared RW port 0, read-only port 1).
// Latency: read data returns with rvalid RD_LAT cycles after the read handshake.
// Backpressure: write beats read A unless read A has starved for STARVE_LIM cycles; read B stalls
// on a same-address write (optional RAMCTL_BYPASS_EN forwards full-mask writes instead).
module ram_2r1w_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WMASKS-1:0] wr_mask,
  input  logic                  ra_valid,
  output logic                  ra_ready,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic                  ra_rvalid,
  output logic [DATA_WIDTH-1:0] ra_rdata,
  input  logic                  rb_valid,
  output logic                  rb_ready,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic                  rb_rvalid,
  output logic [DATA_WIDTH-1:0] rb_rdata,
  output logic                  ram_csb,
  output logic                  ram_web,
  output logic [NUM_WMASKS-1:0] ram_wmask,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_csb1,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  input  logic [DATA_WIDTH-1:0] ram_dout1
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [RD_LAT-1:0] ra_vld_q;
  logic [RD_LAT-1:0] rb_vld_q;
  logic [DATA_WIDTH-1:0] ra_hold_q;
  logic [DATA_WIDTH-1:0] rb_hold_q;
  logic [DATA_WIDTH-1:0] rb_src_dat;

  logic force_ra;
  logic wr_acc;
  logic ra_acc;
  logic rb_acc;
  logic collide;
  logic rb_stall;
  logic rb_fwd;
  logic p1_read;

`ifdef RAMCTL_BYPASS_EN
  logic [RD_LAT-1:0]     rb_fwd_q;
  logic [DATA_WIDTH-1:0] fwd_dat_q [RD_LAT];
`endif

  // Port arbitration and handshakes; readies depend only on valids, addresses and the starve count.
  always_comb begin
    force_ra = ra_valid && (starve_cnt_q == LIM);
    wr_ready = rst_l && !force_ra;
    ra_ready = rst_l && (force_ra || !wr_valid);
    wr_acc   = wr_valid && wr_ready;
    ra_acc   = ra_valid && ra_ready;
    collide  = wr_acc && (rb_addr == wr_addr);
`ifdef RAMCTL_BYPASS_EN
    // A full-mask write fully defines the word, so read B can take it straight from the write bus.
    rb_fwd   = collide && (&wr_mask);
    rb_stall = collide && !(&wr_mask);
`else
    rb_fwd   = 1'b0;
    rb_stall = collide;
`endif
    rb_ready = rst_l && !rb_stall;
    rb_acc   = rb_valid && rb_ready;
    p1_read  = rb_acc && !rb_fwd;

    ram_csb   = !(wr_acc || ra_acc);
    ram_web   = !wr_acc;
    ram_wmask = wr_acc ? wr_mask : '0;
    ram_addr  = wr_acc ? wr_addr : (ra_acc ? ra_addr : '0);
    ram_din   = wr_acc ? wr_data : '0;
    ram_csb1  = !p1_read;
    ram_addr1 = p1_read ? rb_addr : '0;
  end

  // Starvation counter: counts consecutive cycles read A waits, saturating at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (ra_valid && !ra_ready) begin
      starve_cnt_d = (starve_cnt_q == LIM) ? LIM : starve_cnt_q + 4'd1;
    end
  end

  // Read B data source: forwarded write data when the matching response was bypassed.
  always_comb begin
    rb_src_dat = ram_dout1;
`ifdef RAMCTL_BYPASS_EN
    if (rb_fwd_q[RD_LAT-1]) rb_src_dat = fwd_dat_q[RD_LAT-1];
`endif
  end

  // Response outputs: live macro data on the rvalid cycle, held value otherwise, zero in reset.
  always_comb begin
    ra_rvalid = rst_l && ra_vld_q[RD_LAT-1];
    rb_rvalid = rst_l && rb_vld_q[RD_LAT-1];
    ra_rdata  = '0;
    rb_rdata  = '0;
    if (rst_l) begin
      ra_rdata = ra_vld_q[RD_LAT-1] ? ram_dout   : ra_hold_q;
      rb_rdata = rb_vld_q[RD_LAT-1] ? rb_src_dat : rb_hold_q;
    end
  end

  // Sequential state: starve counter, latency pipelines and held read data.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      starve_cnt_q <= '0;
      ra_vld_q     <= '0;
      rb_vld_q     <= '0;
      ra_hold_q    <= '0;
      rb_hold_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ra_vld_q[0]  <= ra_acc;
      rb_vld_q[0]  <= rb_acc;
      for (int i = 1; i < RD_LAT; i++) begin
        ra_vld_q[i] <= ra_vld_q[i-1];
        rb_vld_q[i] <= rb_vld_q[i-1];
      end
      if (ra_vld_q[RD_LAT-1]) ra_hold_q <= ram_dout;
      if (rb_vld_q[RD_LAT-1]) rb_hold_q <= rb_src_dat;
    end
  end

`ifdef RAMCTL_BYPASS_EN
  // Forwarding pipeline: carries bypassed write data alongside the read B valid.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rb_fwd_q <= '0;
      for (int i = 0; i < RD_LAT; i++) fwd_dat_q[i] <= '0;
    end else begin
      rb_fwd_q[0]  <= rb_acc && rb_fwd;
      fwd_dat_q[0] <= wr_data;
      for (int i = 1; i < RD_LAT; i++) begin
        rb_fwd_q[i]  <= rb_fwd_q[i-1];
        fwd_dat_q[i] <= fwd_dat_q[i-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_2r1w_access_ctrl.sv
// Randomized and directed bench for ram_2r1w_access_ctrl with a behavioural RAM macro
// and a transaction-level reference (word array, starve count, response queues).
module tb_ram_2r1w_access_ctrl;
  localparam int AW = 8, DW = 32, MW = 4, LAT = 2, LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l;
  logic wr_valid, wr_ready, ra_valid, ra_ready, ra_rvalid, rb_valid, rb_ready, rb_rvalid;
  logic [AW-1:0] wr_addr, ra_addr, rb_addr, ram_addr, ram_addr1;
  logic [DW-1:0] wr_data, ra_rdata, rb_rdata, ram_din, ram_dout, ram_dout1;
  logic [MW-1:0] wr_mask, ram_wmask;
  logic ram_csb, ram_web, ram_csb1;

  ram_2r1w_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW),
                         .RD_LAT(LAT), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_l(rst_l),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_addr(ra_addr), .ra_rvalid(ra_rvalid), .ra_rdata(ra_rdata),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_addr(rb_addr), .rb_rvalid(rb_rvalid), .rb_rdata(rb_rdata),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_csb1(ram_csb1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5A55A5A;
  endfunction

  // Behavioural macro: LAT-cycle read pipelines, garbage when a port is not read.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] p0 [LAT];
  logic [DW-1:0] p1 [LAT];
  logic ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else if (!ram_csb && !ram_web) begin
      for (int b = 0; b < MW; b++)
        if (ram_wmask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    p0[0] <= (!ram_csb && ram_web) ? ram_mem[ram_addr] : DW'($urandom);
    p1[0] <= (!ram_csb1) ? ram_mem[ram_addr1] : DW'($urandom);
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign ram_dout  = p0[LAT-1];
  assign ram_dout1 = p1[LAT-1];

  // Reference state
  int n_chk = 0, n_err = 0, cyc = 0, starve = 0;
  logic [DW-1:0] ref_mem [256];
  int            qa_due[$], qb_due[$];
  logic [DW-1:0] qa_dat[$], qb_dat[$];
  logic [DW-1:0] last_a = '0, last_b = '0;
  int ra_acc_cyc = -1;
  logic bypass_on;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, check against the reference, advance the reference.
  task automatic step(input logic rst, input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [MW-1:0] wm, input logic rav, input logic [AW-1:0] raa,
                      input logic rbv, input logic [AW-1:0] rba);
    logic frc, e_wr, e_ra, e_rb, wacc, racc, rbacc, coll, byp, av, bv;
    rst_l = rst; wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
    ra_valid = rav; ra_addr = raa; rb_valid = rbv; rb_addr = rba;
    #1;
    frc   = rst && rav && (starve == LIM);
    e_wr  = rst && !frc;
    e_ra  = rst && (frc || !wv);
    wacc  = wv && e_wr;
    racc  = rav && e_ra;
    coll  = wacc && (rba == wa);
    byp   = bypass_on && coll && (wm == 4'hF);
    e_rb  = rst && !(coll && !byp);
    rbacc = rbv && e_rb;

    check_val("wr_ready", 32'(wr_ready), 32'(e_wr));
    check_val("ra_ready", 32'(ra_ready), 32'(e_ra));
    check_val("rb_ready", 32'(rb_ready), 32'(e_rb));
    check_val("ram_csb", 32'(ram_csb), 32'(!(wacc || racc)));
    check_val("ram_web", 32'(ram_web), 32'(!wacc));
    check_val("ram_csb1", 32'(ram_csb1), 32'(!(rbacc && !byp)));
    if (wacc) begin
      check_val("ram_addr_wr", 32'(ram_addr), 32'(wa));
      check_val("ram_din", ram_din, wd);
      check_val("ram_wmask_wr", 32'(ram_wmask), 32'(wm));
    end else if (racc) begin
      check_val("ram_addr_rd", 32'(ram_addr), 32'(raa));
      check_val("ram_wmask_rd", 32'(ram_wmask), 32'(0));
    end
    if (rbacc && !byp) check_val("ram_addr1", 32'(ram_addr1), 32'(rba));

    av = rst && (qa_due.size() > 0) && (qa_due[0] == cyc);
    bv = rst && (qb_due.size() > 0) && (qb_due[0] == cyc);
    check_val("ra_rvalid", 32'(ra_rvalid), 32'(av));
    check_val("rb_rvalid", 32'(rb_rvalid), 32'(bv));
    if (av) begin last_a = qa_dat[0]; void'(qa_due.pop_front()); void'(qa_dat.pop_front()); end
    if (bv) begin last_b = qb_dat[0]; void'(qb_due.pop_front()); void'(qb_dat.pop_front()); end
    if (!rst) begin last_a = '0; last_b = '0; end
    check_val("ra_rdata", ra_rdata, last_a);
    check_val("rb_rdata", rb_rdata, last_b);

    if (!rst) begin
      qa_due.delete(); qa_dat.delete(); qb_due.delete(); qb_dat.delete();
      starve = 0;
    end else begin
      if (racc) begin qa_due.push_back(cyc + LAT); qa_dat.push_back(ref_mem[raa]); ra_acc_cyc = cyc; end
      if (rbacc) begin qb_due.push_back(cyc + LAT); qb_dat.push_back(byp ? wd : ref_mem[rba]); end
      if (wacc) for (int b = 0; b < MW; b++) if (wm[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
      starve = (rav && !e_ra) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef RAMCTL_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst_l = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_mask = 0;
    ra_valid = 0; ra_addr = 0; rb_valid = 0; rb_addr = 0;
    @(negedge clk);

    // Reset held with all valids high
    for (int i = 0; i < 3; i++) step(0, 1, 8'h01, 32'h1, 4'hF, 1, 8'h02, 1, 8'h03);
    step(1, 1, 8'h05, 32'h55, 4'hF, 0, 0, 0, 0);

    // Write then read A, latency LAT
    step(1, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 8'h10, 0, 0);
    check_val("ra_acc_cycle", 32'(ra_acc_cyc), 32'(cyc - 1));
    idle(LAT + 1);

    // Simultaneous write and read A: write first
    step(1, 1, 8'h20, 32'hCAFE0020, 4'hF, 1, 8'h30, 0, 0);
    step(1, 0, 0, 0, 0, 1, 8'h30, 0, 0);
    idle(LAT + 1);

    // Starvation: continuous writes with read A held
    begin
      int start;
      start = cyc;
      for (int i = 0; i < 6; i++) step(1, 1, 8'h50 + 8'(i), DW'($urandom), 4'hF, 1, 8'h20, 0, 0);
      check_val("starve_5th", 32'(ra_acc_cyc - start), 32'(4));
    end
    idle(LAT + 1);

    // Port-1 collision, full mask then partial mask, with retry
    step(1, 1, 8'h40, 32'h12345678, 4'hF, 0, 0, 1, 8'h40);
    step(1, 0, 0, 0, 0, 0, 0, 1, 8'h40);
    idle(LAT + 1);
    step(1, 1, 8'h40, 32'hAABBCCDD, 4'h3, 0, 0, 1, 8'h40);
    step(1, 0, 0, 0, 0, 0, 0, 1, 8'h40);
    idle(LAT + 1);

    // Reset pulse with responses in flight, then a fresh read
    step(1, 0, 0, 0, 0, 1, 8'h10, 1, 8'h40);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(LAT + 2);
    step(1, 0, 0, 0, 0, 1, 8'h10, 1, 8'h20);
    idle(LAT + 1);

    // Randomized traffic over a small address window to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      logic rst, wv, rav, rbv;
      logic [MW-1:0] wm;
      rst = ($urandom_range(0, 199) != 0);
      wv  = ($urandom_range(0, 3) != 0);
      rav = ($urandom_range(0, 2) != 0);
      rbv = ($urandom_range(0, 1) != 0);
      wm  = ($urandom_range(0, 1) != 0) ? 4'hF : MW'($urandom);
      step(rst, wv, AW'($urandom_range(0, 7)), DW'($urandom), wm,
           rav, AW'($urandom_range(0, 7)), rbv, AW'($urandom_range(0, 7)));
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_2r1w_access_ctrl.md
Name: ram_2r1w_access_ctrl

Overview:
Request-side controller placed directly upstream of the 2-read/1-write RAM wrapper, for a single-clock configuration (clk1 tied to clk).
- Accepts one write channel and two read channels through valid/ready handshakes.
- Arbitrates the shared RW port 0 between write and read A, and routes read B to read-only port 1.
- Resolves port-1 same-address write/read collisions and returns read data with a valid strobe after the macro latency.

Parameters:
ADDR_WIDTH, 8, word address width
DATA_WIDTH, 32, data width
NUM_WMASKS, 4, byte-enable width (DATA_WIDTH/8)
RD_LAT, 1, cycles from accepted read to ram_dout/ram_dout1 valid (1..4)
STARVE_LIM, 4, consecutive write-blocked cycles before read A is forced through (1..15)

Ports:
clk  in  1  clock, also drives RAM clk and clk1
rst_l  in  1  synchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  NUM_WMASKS  byte enables
ra_valid  in  1  read A request
ra_ready  out  1  read A accepted
ra_addr  in  ADDR_WIDTH  read A address
ra_rvalid  out  1  read A data valid (1-cycle pulse)
ra_rdata  out  DATA_WIDTH  read A data
rb_valid  in  1  read B request
rb_ready  out  1  read B accepted
rb_addr  in  ADDR_WIDTH  read B address
rb_rvalid  out  1  read B data valid
rb_rdata  out  DATA_WIDTH  read B data
ram_csb  out  1  port 0 chip select, active low
ram_web  out  1  port 0 write enable, active low
ram_wmask  out  NUM_WMASKS  port 0 write mask
ram_addr  out  ADDR_WIDTH  port 0 address
ram_din  out  DATA_WIDTH  port 0 write data
ram_dout  in  DATA_WIDTH  port 0 read data
ram_csb1  out  1  port 1 chip select, active low
ram_addr1  out  ADDR_WIDTH  port 1 address
ram_dout1  in  DATA_WIDTH  port 1 read data

Behaviour:
Reset
- While rst_l is low: all *_ready=0, ram_csb=1, ram_web=1, ram_csb1=1, ram_wmask=0, ram_addr/ram_addr1/ram_din=0, *_rvalid=0, *_rdata=0.
- Starve counter, latency shift registers and forwarding registers are cleared.
- Reset mid-operation drops all in-flight responses: no rvalid after rst_l deasserts for reads accepted before reset.

Port-0 arbitration (combinational from valids and the starve counter)
- Write has priority unless starve_cnt==STARVE_LIM.
- Write accepted: ram_csb=0, ram_web=0, ram_wmask=wr_mask, ram_addr=wr_addr, ram_din=wr_data, ra_ready=0.
- Read A accepted: ram_csb=0, ram_web=1, ram_wmask=0, ram_addr=ra_addr.
- At starve_cnt==STARVE_LIM with ra_valid: wr_ready=0 and read A is accepted.
- Starve counter:
  - increments on each cycle with ra_valid&~ra_ready;
  - clears on read A acceptance or when ra_valid=0;
  - saturates at STARVE_LIM.

Port 1
- rb_ready=1 unless a collision: write accepted this cycle with rb_addr==wr_addr.
- On collision (macro behaviour undefined): rb_ready=0 and ram_csb1=1; read B retries the next cycle and sees the new data.
- Otherwise, on rb_valid: ram_csb1=0, ram_addr1=rb_addr.

Response path
- Per port, an RD_LAT-deep valid shift register.
- Read accepted in cycle N → *_rvalid=1 in cycle N+RD_LAT.
- *_rdata is registered from ram_dout/ram_dout1 in that cycle and held until the next rvalid.
- No response backpressure; sinks must accept every rvalid.
- Back-to-back reads give one response per cycle; order is preserved.
- No valid-to-ready combinational loop: ready never depends on a ready.

Optional Feature:
RAMCTL_BYPASS_EN
- Defined: a port-1 collision with wr_mask all-ones does not stall.
  - rb_ready=1 and ram_csb1=1.
  - wr_data is captured into a forwarding register and delayed RD_LAT cycles.
  - rb_rdata takes the forwarded data at the matching rvalid.
- Partial-mask collisions still stall.
- Undefined: every collision stalls as described under Behaviour.

Test Plan:
- Reset: hold rst_l=0 for 3 cycles with all valids high → all ready=0, ram_csb=ram_csb1=ram_web=1, rvalid=0; release → wr_ready=1 on the first cycle.
- Write 0xDEADBEEF to addr 0x10 with mask 0xF, then ra_addr=0x10 → ra_rvalid exactly RD_LAT cycles after acceptance, with ra_rdata=0xDEADBEEF.
- Simultaneous write addr 0x20 and read A addr 0x30 → write first, ra_ready=0 for one cycle, then read A accepted.
- Continuous writes with ra_valid held, STARVE_LIM=4 → read A accepted on the 5th cycle, wr_ready=0 that cycle, counter cleared.
- Write 0x12345678 to 0x40 (mask 0xF) with rb_addr=0x40 in the same cycle:
  - macro undefined → rb_ready=0, then the next-cycle read returns 0x12345678;
  - RAMCTL_BYPASS_EN defined → no stall, rb_rdata=0x12345678.
  - Repeat with mask 0x3 → stall in both builds.
- Reads accepted, then rst_l pulsed low before rvalid is due → no rvalid after reset; the next read returns correct data.
